fifo_uart_tx: RTL and testbench

Serial transmit stage that sits directly downstream of the team's RAM-based FIFO. It pops one word at a time through the FIFO's `shift_out`/`empty`/`rdata` handshake and sends it on a single asynchronous serial line. Each frame is a start bit, the data bits LSB first, an optional parity bit, and one or two stop bits. It is the drain end of the buffered transmit path.

---
 rtl/fifo_uart_tx.sv | 140 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Serial transmitter draining an upstream FIFO: start bit, WIDTH data bits LSB first,
// optional parity bit, STOP_BITS stop bits. Pops exactly one word per frame.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_shift_out,
    output logic             txd,
    output logic             busy,
    output logic             frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BIT_W-1:0]  r_bit;
    logic [WIDTH-1:0]  r_shift;
    logic              r_par;
    logic              r_txd;

    logic              w_baud_end;
    logic              w_bit_last;
    logic              w_stop_last;
    logic              w_can_fetch;
    logic              w_shift_out;
    logic              w_done;
    logic [WIDTH-1:0]  w_shift_nxt;

    assign w_baud_end  = (r_baud == BAUD_LAST);
    assign w_bit_last  = (r_bit == BIT_LAST);
    assign w_stop_last = (r_bit == STOP_LAST);
    assign w_can_fetch = enable & ~fifo_empty;
    assign w_shift_nxt = r_shift >> 1;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_shift_out = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE:   if (w_can_fetch) w_next = S_FETCH;
            S_FETCH: begin
                // Gated by empty as a safety net; the single-consumer contract keeps it non-empty here.
                w_shift_out = ~fifo_empty;
                w_next      = S_LOAD;
            end
            S_LOAD:   w_next = S_START;
            S_START:  if (w_baud_end) w_next = S_DATA;
            S_DATA: begin
                if (w_baud_end && w_bit_last)
                    w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_baud_end) w_next = S_STOP;
            S_STOP: begin
                if (w_baud_end && w_stop_last) begin
                    w_done = 1'b1;
                    w_next = w_can_fetch ? S_FETCH : S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shift <= fifo_rdata;
                    r_par   <= (^fifo_rdata) ^ (PARITY_ODD != 0);
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_txd   <= 1'b0;
                end
                S_START, S_DATA, S_PARITY, S_STOP: begin
                    r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
                    if (w_baud_end) begin
                        case (r_state)
                            S_START: r_txd <= r_shift[0];
                            S_DATA: begin
                                r_shift <= w_shift_nxt;
                                if (w_bit_last) begin
                                    r_bit <= '0;
                                    r_txd <= (PARITY_EN != 0) ? r_par : 1'b1;
                                end else begin
                                    r_bit <= r_bit + 1'b1;
                                    r_txd <= w_shift_nxt[0];
                                end
                            end
                            S_PARITY: r_txd <= 1'b1;
                            default: begin
                                // Bit counter doubles as the stop-bit counter.
                                r_bit <= w_stop_last ? '0 : r_bit + 1'b1;
                                r_txd <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    r_baud <= '0;
                    r_txd  <= 1'b1;
                end
            endcase
        end
    end

    assign fifo_shift_out = w_shift_out;
    assign frame_done     = w_done;
    assign busy           = (r_state != S_IDLE);
    assign txd            = r_txd;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four configurations side by side, each fed by its own FIFO
// emulation and checked every cycle against a frame-level waveform model.
module tb_fifo_uart_tx;

    localparam int NI  = 4;
    localparam int CPB = 4;

    typedef struct packed {logic t; logic d;} ev_t;
    typedef struct {int g; logic [7:0] data; int len; logic [11:0] bits;} vec_t;

    logic            clk = 1'b0;
    logic            res_n;
    logic [NI-1:0]   en  = '0;
    logic [NI-1:0]   emp = '1;
    logic [NI-1:0]   so, txd, busy, fd;
    logic [7:0]      rd [NI];

    ev_t             exq [NI][$];
    logic [7:0]      fq  [NI][$];
    logic [7:0]      mq  [NI][$];
    logic [NI-1:0]   fpend = '0;
    int              total = 0;
    int              bad   = 0;
    int              pops  [NI];
    int              dones [NI];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            fifo_uart_tx #(
                .WIDTH(8), .CLKS_PER_BIT(CPB),
                .PARITY_EN((gi == 1 || gi == 2) ? 1 : 0),
                .PARITY_ODD((gi == 2) ? 1 : 0),
                .STOP_BITS((gi >= 2) ? 2 : 1)
            ) u_dut (
                .clk(clk), .res_n(res_n), .enable(en[gi]), .fifo_empty(emp[gi]),
                .fifo_rdata(rd[gi]), .fifo_shift_out(so[gi]), .txd(txd[gi]),
                .busy(busy[gi]), .frame_done(fd[gi])
            );
        end
    endgenerate

    function automatic int pe(int g); return (g == 1 || g == 2) ? 1 : 0; endfunction
    function automatic int po(int g); return (g == 2) ? 1 : 0; endfunction
    function automatic int sb(int g); return (g >= 2) ? 2 : 1; endfunction

    // Expected per-cycle line from the pop edge on: one LOAD cycle, then the frame bits.
    function automatic void build(int g, logic [7:0] w);
        logic bl[$];
        ev_t  e;
        bl.push_back(1'b0);
        for (int i = 0; i < 8; i++) bl.push_back(w[i]);
        if (pe(g) != 0) bl.push_back((($countones(w) + po(g)) % 2) == 1);
        for (int i = 0; i < sb(g); i++) bl.push_back(1'b1);
        e.t = 1'b1; e.d = 1'b0;
        exq[g].push_back(e);
        for (int i = 0; i < bl.size(); i++)
            for (int c = 0; c < CPB; c++) begin
                e.t = bl[i];
                e.d = (i == bl.size() - 1) && (c == CPB - 1);
                exq[g].push_back(e);
            end
    endfunction

    task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d @%0t: got %0h want %0h", nm, g, $time, act, exp);
        end
    endtask

    task automatic push(int g, logic [7:0] w);
        fq[g].push_back(w);
        mq[g].push_back(w);
        emp[g] = 1'b0;
    endtask

    task automatic cyc();
        logic [NI-1:0] pop_s, dec;
        logic          rst_s, was;
        logic [7:0]    w;
        logic          et, ed;
        rst_s = res_n;
        for (int g = 0; g < NI; g++) begin
            pop_s[g] = so[g] & ~emp[g];
            dec[g]   = en[g] && (mq[g].size() > 0);
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            if (pop_s[g]) begin
                rd[g]  = fq[g].pop_front();
                emp[g] = (fq[g].size() == 0);
            end
            if (!rst_s) begin
                exq[g].delete();
                fpend[g] = 1'b0;
            end else begin
                was = fpend[g];
                if (exq[g].size() > 0) void'(exq[g].pop_front());
                if (was) begin
                    fpend[g] = 1'b0;
                    w = mq[g].pop_front();
                    build(g, w);
                end else if (exq[g].size() == 0 && dec[g]) begin
                    fpend[g] = 1'b1;
                end
            end
        end
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            et = (exq[g].size() == 0) ? 1'b1 : exq[g][0].t;
            ed = (exq[g].size() == 0) ? 1'b0 : exq[g][0].d;
            chk("txd", g, 32'(txd[g]), 32'(et));
            chk("frame_done", g, 32'(fd[g]), 32'(ed));
            chk("busy", g, 32'(busy[g]), 32'(fpend[g] || exq[g].size() > 0));
            chk("shift_out", g, 32'(so[g]), 32'(fpend[g]));
            pops[g]  += int'(so[g]);
            dones[g] += int'(fd[g]);
        end
    endtask

    task automatic wait_fall(int g);
        int n = 0;
        while (txd[g] !== 1'b0 && n < 20) begin cyc(); n++; end
        chk("start_timeout", g, 32'(txd[g]), 32'(0));
    endtask

    task automatic wait_done(int g);
        int n = 0;
        while (fd[g] !== 1'b1 && n < 100) begin cyc(); n++; end
        chk("done_timeout", g, 32'(fd[g]), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[$];
        vec_t        v;
        int          p0, d0, k, len, hi;
        logic [11:0] bits;
        logic        anyb, anys, blow;

        for (int g = 0; g < NI; g++) begin pops[g] = 0; dones[g] = 0; rd[g] = '0; end
        vt.push_back('{0, 8'hA5, 40, 12'h34A});
        vt.push_back('{1, 8'hA5, 44, 12'h54A});
        vt.push_back('{2, 8'hA5, 48, 12'hF4A});
        vt.push_back('{1, 8'h01, 44, 12'h602});
        vt.push_back('{3, 8'h00, 44, 12'h600});
        vt.push_back('{0, 8'h3C, 40, 12'h278});

        // Reset values, before any clock edge
        res_n = 1'b1;
        #1 res_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("rst_txd", g, 32'(txd[g]), 32'(1));
            chk("rst_busy", g, 32'(busy[g]), 32'(0));
            chk("rst_so", g, 32'(so[g]), 32'(0));
            chk("rst_done", g, 32'(fd[g]), 32'(0));
        end
        repeat (3) cyc();
        res_n = 1'b1;

        // Empty FIFO with enable high: nothing happens
        en = '1; anyb = 1'b0; anys = 1'b0;
        repeat (100) begin cyc(); anyb |= |busy; anys |= |so; end
        chk("empty_busy", 0, 32'(anyb), 32'(0));
        chk("empty_pop", 0, 32'(anys), 32'(0));
        chk("empty_txd", 0, 32'(txd), 32'('1 & {NI{1'b1}}));
        en = '0;

        // Non-empty with enable low: no pop
        push(0, 8'h5A);
        repeat (30) cyc();
        chk("disabled_pops", 0, 32'(pops[0]), 32'(0));

        // Enable dropped mid-frame: frame completes, no further pop
        push(0, 8'h33);
        p0 = pops[0]; d0 = dones[0];
        en[0] = 1'b1;
        wait_fall(0);
        repeat (8) cyc();
        en[0] = 1'b0;
        repeat (60) cyc();
        chk("drop_pops", 0, 32'(pops[0] - p0), 32'(1));
        chk("drop_dones", 0, 32'(dones[0] - d0), 32'(1));
        chk("drop_busy", 0, 32'(busy[0]), 32'(0));
        chk("drop_left", 0, 32'(fq[0].size()), 32'(1));
        en[0] = 1'b1;
        repeat (60) cyc();
        en[0] = 1'b0;
        repeat (3) cyc();

        // Single-frame vectors: length, bit sequence, one pop, one done pulse
        foreach (vt[i]) begin
            v = vt[i];
            p0 = pops[v.g]; d0 = dones[v.g]; bits = '0;
            push(v.g, v.data);
            en[v.g] = 1'b1;
            wait_fall(v.g);
            en[v.g] = 1'b0;
            k = 0;
            while (k < 100) begin
                if (k % CPB == 2) bits[k / CPB] = txd[v.g];
                if (fd[v.g]) break;
                cyc();
                k++;
            end
            len = k + 1;
            repeat (3) cyc();
            chk("vec_len", v.g, 32'(len), 32'(v.len));
            chk("vec_bits", v.g, 32'(bits), 32'(v.bits));
            chk("vec_pops", v.g, 32'(pops[v.g] - p0), 32'(1));
            chk("vec_dones", v.g, 32'(dones[v.g] - d0), 32'(1));
            chk("vec_idle", v.g, 32'(busy[v.g]), 32'(0));
        end

        // Back-to-back frames, 2 stop bits: exactly 2 extra high cycles, busy never drops
        p0 = pops[3];
        push(3, 8'h00);
        push(3, 8'hFF);
        en[3] = 1'b1;
        wait_fall(3);
        blow = 1'b0;
        k = 0;
        while (fd[3] !== 1'b1 && k < 100) begin cyc(); blow |= ~busy[3]; k++; end
        cyc();
        hi = 0;
        while (txd[3] === 1'b1 && hi < 20) begin blow |= ~busy[3]; hi++; cyc(); end
        chk("b2b_gap", 3, 32'(hi), 32'(2));
        wait_done(3);
        en[3] = 1'b0;
        chk("b2b_busy_low", 3, 32'(blow), 32'(0));
        repeat (3) cyc();
        chk("b2b_pops", 3, 32'(pops[3] - p0), 32'(2));

        // Reset during the 4th data bit, then a fresh frame
        push(0, 8'hC3);
        en[0] = 1'b1;
        wait_fall(0);
        repeat (17) cyc();
        #2 res_n = 1'b0;
        #1;
        chk("mrst_txd", 0, 32'(txd[0]), 32'(1));
        chk("mrst_busy", 0, 32'(busy[0]), 32'(0));
        chk("mrst_so", 0, 32'(so[0]), 32'(0));
        repeat (2) cyc();
        push(0, 8'h81);
        res_n = 1'b1;
        cyc();
        chk("post_rst_fetch", 0, 32'(so[0]), 32'(1));
        cyc();
        chk("post_rst_load", 0, 32'(txd[0]), 32'(1));
        cyc();
        chk("post_rst_start", 0, 32'(txd[0]), 32'(0));
        wait_done(0);
        en[0] = 1'b0;
        repeat (3) cyc();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < NI; g++) begin
                if ($urandom_range(0, 11) == 0 && fq[g].size() < 6)
                    push(g, 8'($urandom_range(0, 255)));
                if ($urandom_range(0, 39) == 0) en[g] = ~en[g];
            end
            cyc();
        end
        en = '1;
        k = 0;
        while (k < 2000) begin
            anyb = 1'b0;
            for (int g = 0; g < NI; g++)
                anyb |= (fq[g].size() > 0) || (exq[g].size() > 0) || fpend[g];
            if (!anyb) break;
            cyc();
            k++;
        end
        chk("drain_timeout", 0, 32'(anyb), 32'(0));
        repeat (3) cyc();
        for (int g = 0; g < NI; g++) chk("final_idle", g, 32'(busy[g]), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
